// File: rtl/mul8_sequencer.sv
// mul8_sequencer: 8x8 -> 16 unsigned multiply built from
// four passes through one shared 4x4 array multiplier.
module mul8_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_p,
  input  logic        out_ready,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        busy,
  output logic [7:0]  done_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc_q;
  logic [15:0] acc_d;
  logic [15:0] pp;
  logic [7:0]  cnt_q;

  // Nibble select and partial-product alignment for the current step
  always_comb begin
    mul_a = 4'h0;
    mul_b = 4'h0;
    pp    = 16'h0000;
    unique case (state_q)
      S0: begin
        mul_a = a_q[3:0];
        mul_b = b_q[3:0];
        pp    = {8'h00, mul_p};
      end
      S1: begin
        mul_a = a_q[7:4];
        mul_b = b_q[3:0];
        pp    = {4'h0, mul_p, 4'h0};
      end
      S2: begin
        mul_a = a_q[3:0];
        mul_b = b_q[7:4];
        pp    = {4'h0, mul_p, 4'h0};
      end
      S3: begin
        mul_a = a_q[7:4];
        mul_b = b_q[7:4];
        pp    = {mul_p, 8'h00};
      end
      default: begin
        mul_a = 4'h0;
        mul_b = 4'h0;
        pp    = 16'h0000;
      end
    endcase
  end

  // Max product 0xFE01 fits, so the add never overflows
  assign acc_d = acc_q + pp;

  // Sequencer: accept, four accumulate steps, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc_q   <= 16'h0000;
      cnt_q   <= 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            acc_q   <= 16'h0000;
            state_q <= S0;
          end
        end
        S0: begin
          acc_q   <= acc_d;
          state_q <= S1;
        end
        S1: begin
          acc_q   <= acc_d;
          state_q <= S2;
        end
        S2: begin
          acc_q   <= acc_d;
          state_q <= S3;
        end
        S3: begin
          acc_q   <= acc_d;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            cnt_q   <= cnt_q + 8'h01;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = acc_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_mul8_sequencer.sv
// tb_mul8_sequencer: directed checks of the nibble
// schedule, handshakes, reset and done counter wrap.
module tb_mul8_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_p;
  logic        out_ready;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;
  logic        busy;
  logic [7:0]  done_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_cnt;

  mul8_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_p     (out_p),
    .out_ready (out_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  // 4x4 array multiplier: AND-plane rows summed with shifts
  always_comb begin
    mul_p = 8'h00;
    for (int i = 0; i < 4; i++)
      if (mul_b[i]) mul_p = mul_p + ({4'h0, mul_a} << i);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) chk({tag, "_rdy_timeout"}, 0, 1);
  endtask

  // Single request with out_ready high; checks latency and product
  task automatic run_op(input string tag,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [15:0] exp);
    wait_ready(tag);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    if (out_valid !== 1'b0) chk({tag, "_early"}, out_valid, 0);
    tick();
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_p"}, out_p, exp);
    tick();
    exp_cnt = exp_cnt + 8'h01;
    chk({tag, "_cnt"}, done_cnt, exp_cnt);
  endtask

  logic [7:0]  va [4] = '{8'hFF, 8'h00, 8'h0F, 8'h80};
  logic [7:0]  vb [4] = '{8'hFF, 8'hA5, 8'hF0, 8'h02};
  logic [15:0] vp [4] = '{16'hFE01, 16'h0000, 16'h0E10, 16'h0100};

  initial begin
    int last_acc;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] hold_p;

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = 8'h00;
    in_b = 8'h00;
    out_ready = 1'b0;
    exp_cnt = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", done_cnt, 0);
    chk("rst_mul", {mul_a, mul_b}, 0);

    // 0x12 * 0x34: nibble schedule and latency
    in_a = 8'h12;
    in_b = 8'h34;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s0_mul", {mul_a, mul_b}, 8'h24);
    chk("s0_busy", busy, 1);
    chk("s0_rdy", in_ready, 0);
    tick();
    chk("s1_mul", {mul_a, mul_b}, 8'h14);
    tick();
    chk("s2_mul", {mul_a, mul_b}, 8'h23);
    tick();
    chk("s3_mul", {mul_a, mul_b}, 8'h13);
    chk("s3_vld", out_valid, 0);
    tick();
    chk("e4_vld", out_valid, 1);
    chk("e4_p", out_p, 16'h03A8);
    chk("done_mul", {mul_a, mul_b}, 0);
    tick();
    exp_cnt = 8'h01;
    chk("e5_vld", out_valid, 0);
    chk("e5_cnt", done_cnt, exp_cnt);
    chk("e5_rdy", in_ready, 1);

    // Corner operands back-to-back, in_valid held high
    last_acc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_a = va[k];
      in_b = vb[k];
      tick();
      if (k > 0) chk("b2b_gap", cyc - last_acc, 6);
      last_acc = cyc;
      chk("b2b_busy", busy, 1);
      tick();
      tick();
      tick();
      tick();
      chk("b2b_vld", out_valid, 1);
      chk("b2b_p", out_p, vp[k]);
      tick();
      exp_cnt = exp_cnt + 8'h01;
      chk("b2b_cnt", done_cnt, exp_cnt);
    end
    in_valid = 1'b0;

    // Backpressure: 0x5A * 0x3C = 0x1518
    out_ready = 1'b0;
    in_a = 8'h5A;
    in_b = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("bp_vld", out_valid, 1);
    chk("bp_p", out_p, 16'h1518);
    hold_p = out_p;
    in_valid = 1'b1;
    in_a = 8'h11;
    in_b = 8'h22;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_p", out_p, 16'h1518);
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_cnt", done_cnt, exp_cnt);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 8'h01;
    chk("bp_release_vld", out_valid, 0);
    chk("bp_release_cnt", done_cnt, exp_cnt);
    tick();
    tick();
    chk("bp_one_hs", done_cnt, exp_cnt);
    chk("bp_idle", busy, 0);

    // Reset in S2
    in_a = 8'h33;
    in_b = 8'h44;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_s2_mul", {mul_a, mul_b}, 8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 8'h00;
    chk("mid_busy", busy, 0);
    chk("mid_rdy", in_ready, 1);
    chk("mid_vld", out_valid, 0);
    chk("mid_cnt", done_cnt, 0);
    chk("mid_p", out_p, 0);
    run_op("post_rst", 8'h07, 8'h09, 16'h003F);

    // Counter wrap over 256 random requests
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 8'h00;
    for (int k = 0; k < 256; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op("rnd", ra, rb, 16'(ra) * 16'(rb));
    end
    chk("wrap_cnt", done_cnt, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul8_sequencer.md
# mul8_sequencer

Multi-cycle controller that computes an unsigned 8x8 -> 16-bit product by time-sharing one external 4x4 combinational array multiplier. It splits each operand into nibbles, drives the four nibble pairs onto the multiplier in sequence, and accumulates the shifted partial products. It sits between a valid/ready request source and the 4x4 multiplier instance, and is the only block that drives the multiplier's operand inputs.

## Interface

Parameters:
- none (widths fixed: 8-bit operands, 4x4 datapath, 16-bit result).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request operands are valid.
- `in_a`  in  8  multiplicand.
- `in_b`  in  8  multiplier.
- `in_ready`  out  1  block can accept a request.
- `out_valid`  out  1  `out_p` holds a finished product.
- `out_p`  out  16  product `in_a*in_b`.
- `out_ready`  in  1  consumer accepts `out_p`.
- `mul_a`  out  4  nibble to the 4x4 multiplier m input.
- `mul_b`  out  4  nibble to the 4x4 multiplier q input.
- `mul_p`  in  8  8-bit product returned combinationally by the multiplier.
- `busy`  out  1  high in any state other than IDLE.
- `done_cnt`  out  8  count of completed output handshakes; wraps 0xFF -> 0x00.

## Operation

- FSM states: IDLE, S0, S1, S2, S3, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid & in_ready` at an edge: register `a=in_a` and `b=in_b`, clear `acc`, go to S0.
  - `in_a`/`in_b` are sampled only on the accept edge.
- Step schedule, with `mul_a`/`mul_b` combinational from the registered operands and state:
  - S0: `a[3:0] x b[3:0]`, `acc += mul_p`.
  - S1: `a[7:4] x b[3:0]`, `acc += mul_p<<4`.
  - S2: `a[3:0] x b[7:4]`, `acc += mul_p<<4`.
  - S3: `a[7:4] x b[7:4]`, `acc += mul_p<<8`, go to DONE.
  - Each step advances unconditionally on the next edge.
- Width rules:
  - `acc` is 16 bits; partial products are zero-extended to 16 bits before the shift and add.
  - The maximum result is 0xFE01, so there is no overflow and no truncation.
- `mul_a`/`mul_b` are 0 in IDLE and DONE.
- DONE:
  - `out_valid=1`, `out_p=acc`, both held stable until `out_ready`.
  - On `out_valid & out_ready`: go to IDLE and increment `done_cnt`.
- `in_ready=0` in S0..S3 and DONE. Requests there are ignored (not queued); the source keeps `in_valid` asserted.
- `busy = (state != IDLE)`.
- `rst` takes priority over every other event, including mid-step and in DONE with `out_ready` high.
  - Effect: state=IDLE, `a`/`b`/`acc` cleared, pending result discarded, `done_cnt` cleared.

## Timing

- Reset values:
  - `in_ready=1`, `out_valid=0`, `out_p=0x0000`, `busy=0`, `done_cnt=0x00`, `mul_a=0`, `mul_b=0`.
- Latency:
  - Accept edge E0 enters S0.
  - `out_valid` rises after edge E4 (4 cycles after accept).
- Throughput:
  - With `out_ready` held high, DONE lasts 1 cycle and IDLE is re-entered after E5.
  - The next accept is possible at E6, giving a minimum issue interval of 6 cycles.
- Multiplier path: `mul_p` is sampled on the same edge that ends its step; the 4x4 multiplier plus 16-bit add must close in one cycle.
- Backpressure: DONE persists indefinitely while `out_ready=0`. `out_p`, `done_cnt` and `busy` stay constant.
- `done_cnt` changes only on the output-handshake edge.

## Test plan

- Reset, then `in_a=0x12`, `in_b=0x34`, `in_valid=1` for one cycle, `out_ready=1`:
  - `mul_a`/`mul_b` sequence must be 2/4, 1/4, 2/3, 1/3.
  - `out_valid` rises 4 cycles after accept with `out_p=0x03A8`.
  - `done_cnt=1`.
- Corner operands back-to-back with `in_valid` held high:
  - 0xFF*0xFF -> 0xFE01; 0x00*0xA5 -> 0x0000; 0x0F*0xF0 -> 0x0E10; 0x80*0x02 -> 0x0100.
  - Accepts must be 6 cycles apart.
- Backpressure: `out_ready=0` for 10 cycles after `out_valid`.
  - `out_p` must hold, `in_ready=0`, and a new `in_valid` is ignored.
  - Raising `out_ready` completes exactly one handshake.
- Reset mid-operation: assert `rst` in S2.
  - Next cycle: `busy=0`, `in_ready=1`, `out_valid=0`, `done_cnt=0`.
  - A fresh 0x07*0x09 request returns 0x003F.
- Counter wrap: 256 random unsigned requests checked against a reference `a*b`.
  - `done_cnt` must read 0x00 after the 256th handshake.
  - The bench uses the real 4x4 array multiplier on `mul_*`.
